mc_control_fsm: RTL and testbench

Multi-cycle control state machine that sequences the shared ALU, register file, unified memory and PC of the multi-cycle RISC-V core. Each cycle it decodes the current state and the latched instruction opcode into datapath controls, including the 2-bit ALUOp consumed by the ALU control unit. It uses the ALU branch flag (`alu_bcond`) to choose between the taken-branch and fall-through paths.

---
 rtl/mc_control_fsm.sv | 175 +++++++++++++++++
 tb/tb_mc_control_fsm.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multi-cycle RISC-V control FSM: sequences IF/ID/EX/MEM/WB/BR and decodes datapath controls.
// Optional `MEM_WAIT_EN adds a mem_ready handshake that stretches IF and MEM.
module mc_control_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        alu_bcond,
`ifdef MEM_WAIT_EN
  input  logic        mem_ready,
`endif
  output logic        pc_write,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic [1:0]  mem_to_reg,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        is_ecall,
  output logic        inst_done,
  output logic [31:0] num_inst
);

  typedef enum logic [2:0] {
    StIf  = 3'd0,
    StId  = 3'd1,
    StEx  = 3'd2,
    StMem = 3'd3,
    StWb  = 3'd4,
    StBr  = 3'd5
  } state_e;

  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpIarith = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpEcall  = 7'b1110011;

  state_e      state_q, state_d;
  logic [31:0] num_inst_q;
  logic        mem_ready_w;

`ifdef MEM_WAIT_EN
  assign mem_ready_w = mem_ready;
`else
  assign mem_ready_w = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 2'b00;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    is_ecall   = 1'b0;
    inst_done  = 1'b0;

    unique case (state_q)
      StIf: begin
        mem_read = 1'b1;
        ir_write = mem_ready_w;
        if (mem_ready_w) state_d = StId;
      end
      StId: begin
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
        if (opcode == OpEcall) begin
          is_ecall = 1'b1;
          state_d  = StIf;
        end else begin
          state_d = StEx;
        end
      end
      StEx: begin
        state_d = StIf;
        case (opcode)
          OpRtype: begin
            alu_src_a = 2'b01;
            alu_op    = 2'b01;
            state_d   = StWb;
          end
          OpIarith: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            alu_op    = 2'b10;
            state_d   = StWb;
          end
          OpLoad, OpStore: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            state_d   = StMem;
          end
          OpBranch: begin
            alu_src_a = 2'b01;
            alu_op    = 2'b11;
            if (alu_bcond) state_d = StBr;
          end
          OpJal, OpJalr: begin
            // rd gets the pre-edge PC while PC loads the jump target at the same edge
            reg_write  = 1'b1;
            mem_to_reg = 2'b10;
            alu_src_a  = (opcode == OpJal) ? 2'b10 : 2'b01;
            alu_src_b  = 2'b10;
            pc_write   = 1'b1;
          end
          default: ;
        endcase
      end
      StMem: begin
        i_or_d = 1'b1;
        if (opcode == OpLoad) begin
          mem_read = 1'b1;
          if (mem_ready_w) state_d = StWb;
        end else begin
          mem_write = (opcode == OpStore);
          if (mem_ready_w) state_d = StIf;
        end
      end
      StWb: begin
        reg_write  = 1'b1;
        mem_to_reg = (opcode == OpLoad) ? 2'b01 : 2'b00;
        state_d    = StIf;
      end
      StBr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = StIf;
      end
      default: state_d = StIf;
    endcase

    inst_done = (state_q != StIf) && (state_d == StIf);

    // Nothing may fire while the core is held in reset.
    if (reset) begin
      pc_write   = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      mem_to_reg = 2'b00;
      reg_write  = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      is_ecall   = 1'b0;
      inst_done  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIf;
      num_inst_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (inst_done) num_inst_q <= num_inst_q + 32'd1;
    end
  end

  assign num_inst = num_inst_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized bench for mc_control_fsm: each instruction expands into a list of expected
// per-cycle control vectors, checked every cycle by a single compare process.
module tb_mc_control_fsm;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpEcall  = 7'b1110011;
  localparam logic [6:0] OpOther  = 7'b1111111;

  typedef struct packed {
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       is_ecall;
    logic       inst_done;
    logic       mem_wait;
  } ctl_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic        alu_bcond;
  logic        mem_ready;
  logic        pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write, is_ecall, inst_done;
  logic [1:0]  mem_to_reg, alu_src_a, alu_src_b, alu_op;
  logic [31:0] num_inst;

  int          checks = 0;
  int          errors = 0;
  ctl_t        plan[$];
  ctl_t        exp_q = '0;
  logic        exp_valid = 1'b0;
  logic [31:0] exp_cnt = 32'd0;
  string       cur_name = "reset";
  ctl_t        act_v, exp_v;

  always #10 clk = ~clk;

  mc_control_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .alu_bcond  (alu_bcond),
`ifdef MEM_WAIT_EN
    .mem_ready  (mem_ready),
`endif
    .pc_write   (pc_write),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .is_ecall   (is_ecall),
    .inst_done  (inst_done),
    .num_inst   (num_inst)
  );

  function automatic ctl_t sample();
    ctl_t s;
    s = {pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_write,
         alu_src_a, alu_src_b, alu_op, is_ecall, inst_done, 1'b0};
    return s;
  endfunction

  // Cycle-by-cycle control vectors an instruction must produce, straight from the opcode rules.
  function automatic void build_plan(input logic [6:0] op, input logic taken);
    ctl_t c;
    plan.delete();
    c = '0; c.mem_read = 1'b1; c.ir_write = 1'b1; c.mem_wait = 1'b1;
    plan.push_back(c);
    c = '0; c.alu_src_b = 2'b01; c.pc_write = 1'b1; c.is_ecall = (op == OpEcall);
    plan.push_back(c);
    if (op != OpEcall) begin
      c = '0;
      case (op)
        OpR: begin
          c.alu_src_a = 2'b01; c.alu_op = 2'b01; plan.push_back(c);
          c = '0; c.reg_write = 1'b1; plan.push_back(c);
        end
        OpI: begin
          c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.alu_op = 2'b10; plan.push_back(c);
          c = '0; c.reg_write = 1'b1; plan.push_back(c);
        end
        OpLoad, OpStore: begin
          c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; plan.push_back(c);
          c = '0; c.i_or_d = 1'b1; c.mem_wait = 1'b1;
          if (op == OpLoad) begin
            c.mem_read = 1'b1; plan.push_back(c);
            c = '0; c.reg_write = 1'b1; c.mem_to_reg = 2'b01; plan.push_back(c);
          end else begin
            c.mem_write = 1'b1; plan.push_back(c);
          end
        end
        OpBranch: begin
          c.alu_src_a = 2'b01; c.alu_op = 2'b11; plan.push_back(c);
          if (taken) begin
            c = '0; c.alu_src_a = 2'b10; c.alu_src_b = 2'b10; c.pc_write = 1'b1;
            plan.push_back(c);
          end
        end
        OpJal, OpJalr: begin
          c.reg_write = 1'b1; c.mem_to_reg = 2'b10; c.alu_src_b = 2'b10; c.pc_write = 1'b1;
          c.alu_src_a = (op == OpJal) ? 2'b10 : 2'b01;
          plan.push_back(c);
        end
        default: plan.push_back(c);
      endcase
    end
    c = plan.pop_back();
    c.inst_done = 1'b1;
    plan.push_back(c);
  endfunction

  always @(negedge clk) begin
    if (exp_valid) begin
      act_v = sample();
      exp_v = exp_q;
      exp_v.mem_wait = 1'b0;
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL ctl[%s] t=%0t got %b want %b", cur_name, $time, act_v, exp_v);
      end
      checks++;
      if (num_inst !== exp_cnt) begin
        errors++;
        $display("FAIL num_inst[%s] t=%0t got %0d want %0d", cur_name, $time, num_inst, exp_cnt);
      end
    end
  end

  // Runs plan steps [start, stop) of a fresh plan for op; called and returns at posedge+1.
  task automatic run_inst(input logic [6:0] op, input logic taken, input int start,
                          input int stop);
    ctl_t e;
    logic rdy;
    int   waits;
    int   last;
    build_plan(op, taken);
    opcode = op;
    last = (stop < 0) ? plan.size() : stop;
    for (int i = start; i < last; i++) begin
      waits = 0;
      forever begin
        rdy = 1'b1;
`ifdef MEM_WAIT_EN
        if (plan[i].mem_wait && waits < 4) rdy = 1'($urandom_range(0, 1));
`endif
        mem_ready = rdy;
        alu_bcond = (op == OpBranch && i == 2) ? taken : 1'($urandom_range(0, 1));
        e = plan[i];
        if (!rdy) begin
          e.ir_write  = 1'b0;
          e.inst_done = 1'b0;
        end
        $sformat(cur_name, "op%b step%0d", op, i);
        exp_q = e;
        @(posedge clk);
        #1;
        if (e.inst_done) exp_cnt = exp_cnt + 32'd1;
        if (rdy) break;
        waits++;
      end
    end
  endtask

  task automatic lit_check(input string name, input logic ok, input logic [31:0] got,
                           input logic [31:0] want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  logic [6:0] cpi_ops[10] = '{OpR, OpI, OpLoad, OpStore, OpBranch, OpBranch, OpJal, OpJalr,
                              OpEcall, OpOther};
  int         cpi_len[10] = '{4, 4, 5, 4, 4, 3, 3, 3, 2, 3};
  logic [6:0] known[9]    = '{OpR, OpI, OpLoad, OpStore, OpBranch, OpJal, OpJalr, OpEcall,
                              OpOther};

  initial begin
    ctl_t jal_ex;
    ctl_t s;
    logic [6:0] op;

    // Pin the model against hand-written cycle counts and one literal JAL EX vector.
    for (int k = 0; k < 10; k++) begin
      build_plan(cpi_ops[k], (k == 4));
      lit_check($sformatf("cpi_%0d", k), plan.size() == cpi_len[k], plan.size(), cpi_len[k]);
    end
    build_plan(OpJal, 1'b0);
    jal_ex = '{pc_write: 1'b1, i_or_d: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
               ir_write: 1'b0, mem_to_reg: 2'b10, reg_write: 1'b1, alu_src_a: 2'b10,
               alu_src_b: 2'b10, alu_op: 2'b00, is_ecall: 1'b0, inst_done: 1'b1,
               mem_wait: 1'b0};
    lit_check("jal_ex_model", plan[2] == jal_ex, 32'(plan[2]), 32'(jal_ex));

    reset     = 1'b1;
    opcode    = OpR;
    alu_bcond = 1'b0;
    mem_ready = 1'b1;
    exp_q     = '0;
    exp_cnt   = 32'd0;
    exp_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed walk through every instruction class.
    run_inst(OpR, 1'b0, 0, -1);
    lit_check("num_after_rtype", num_inst == 32'd1, num_inst, 32'd1);
    run_inst(OpLoad, 1'b0, 0, -1);
    run_inst(OpStore, 1'b0, 0, -1);
    lit_check("num_after_ldst", num_inst == 32'd3, num_inst, 32'd3);
    run_inst(OpBranch, 1'b1, 0, -1);
    run_inst(OpBranch, 1'b0, 0, -1);
    run_inst(OpJal, 1'b0, 0, -1);
    run_inst(OpEcall, 1'b0, 0, -1);
    lit_check("num_after_directed", num_inst == 32'd7, num_inst, 32'd7);

    // Short async reset pulse inside EX of a LOAD: LOAD abandoned, fetch restarts at once.
    run_inst(OpLoad, 1'b0, 0, 2);
    cur_name = "load_ex_before_reset";
    exp_q = plan[2];
    @(negedge clk);
    #2;
    reset = 1'b1;
    exp_cnt = 32'd0;
    #1;
    s = sample();
    lit_check("outputs_in_reset", s == '0, 32'(s), 32'd0);
    lit_check("num_async_clear", num_inst == 32'd0, num_inst, 32'd0);
    #1;
    reset = 1'b0;
    #1;
    lit_check("fetch_after_pulse", mem_read && ir_write && !i_or_d && !mem_write && !pc_write,
              32'(sample()), 32'h0);
    @(posedge clk);
    #1;
    run_inst(OpLoad, 1'b0, 1, -1);
    lit_check("num_after_abort", num_inst == 32'd1, num_inst, 32'd1);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 4) == 0) op = 7'($urandom);
      else op = known[$urandom_range(0, 8)];
      run_inst(op, 1'($urandom_range(0, 1)), 0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
